// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: instruction classes, FSM states and exception cause codes.
package mc_pkg;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BR      = 3'd3,
        CLS_JMP     = 3'd4,
        CLS_ERET    = 3'd5,
        CLS_MTC0    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_e;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MDWAIT = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_BRANCH = 4'd6,
        ST_JUMP   = 4'd7,
        ST_ERET   = 4'd8,
        ST_DONE   = 4'd9,
        ST_EXC    = 4'd10
    } state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_IBE = 5'd6;
    localparam logic [4:0] EXC_DBE = 5'd7;
    localparam logic [4:0] EXC_RI  = 5'd10;

    // States in which the sequencer owns an outstanding bus request.
    function automatic logic is_bus_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Memory/bridge handshake seen by the sequencer: request, write qualifier and completion.
interface mc_seq_ctrl_if;
    logic bus_req;
    logic bus_we;
    logic bus_rdy;

    modport master (output bus_req, output bus_we, input bus_rdy);
    modport slave  (input bus_req, input bus_we, output bus_rdy);
endinterface

// File: rtl/mc_irq_prio.sv
// Masked interrupt priority encoder: any enabled request raises pend, lowest active index wins.
module mc_irq_prio #(
    parameter int IRQ_N = 6
) (
    input  logic [IRQ_N-1:0] irq,
    input  logic [IRQ_N-1:0] irq_mask,
    input  logic             en,
    output logic             pend,
    output logic [2:0]       irq_id
);

    logic [IRQ_N-1:0] act_s;

    assign act_s = irq & irq_mask & {IRQ_N{en}};
    assign pend  = |act_s;

    // Scan from the top line down so the lowest active index is written last.
    always_comb begin
        irq_id = 3'd0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            irq_id = act_s[i] ? 3'(i) : irq_id;
        end
    end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multicycle CPU sequencing FSM with variable-latency bus, mult/div stall and exceptions.
// Optional bus timeout (causes IBE/DBE) is built only when MC_BUS_TIMEOUT_EN is defined.
module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int IRQ_N = 6
`ifdef MC_BUS_TIMEOUT_EN
    , parameter int TIMEOUT_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cls,
    input  logic              is_md,
    input  logic              link,
    input  logic              br_taken,
    input  logic              md_busy,
    input  logic [IRQ_N-1:0]  irq,
    input  logic [IRQ_N-1:0]  irq_mask,
    input  logic              ie,
    input  logic              exl,
    mc_seq_ctrl_if.master     bus,
    output logic              ir_we,
    output logic              pc_we,
    output logic              reg_we,
    output logic              cp0_we,
    output logic              exl_set,
    output logic              exl_clr,
    output logic [4:0]        exc_code,
    output logic [2:0]        irq_id,
    output logic              fetch
);

    state_e     state_r, state_nxt_s;
    cls_e       cls_s;
    logic       rdy_s, pend_s, tmo_hit_s;
    logic [2:0] pend_id_s, id_nxt_s, id_r;
    logic [4:0] cause_nxt_s, cause_r;
    logic       ir_we_s, pc_we_s, reg_we_s, cp0_we_s, exl_set_s, exl_clr_s;

    assign cls_s = cls_e'(cls);
    // A completion is only meaningful while a request is actually on the bus.
    assign rdy_s = bus.bus_rdy & ~rst;

    mc_irq_prio #(.IRQ_N(IRQ_N)) u_irq_prio (
        .irq      (irq),
        .irq_mask (irq_mask),
        .en       (ie & ~exl),
        .pend     (pend_s),
        .irq_id   (pend_id_s)
    );

`ifdef MC_BUS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] tmo_cnt_r;

    assign tmo_hit_s = is_bus_state(state_r) && !bus.bus_rdy && (tmo_cnt_r == TMO_LAST);

    // Wait-cycle counter, restarted whenever the FSM changes state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {TIMEOUT_W{1'b0}};
        end else if (state_nxt_s != state_r) begin
            tmo_cnt_r <= {TIMEOUT_W{1'b0}};
        end else if (is_bus_state(state_r) && !bus.bus_rdy) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cause and interrupt index captured on the way into EXC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_r <= EXC_INT;
            id_r    <= 3'd0;
        end else if (state_nxt_s == ST_EXC) begin
            cause_r <= cause_nxt_s;
            id_r    <= id_nxt_s;
        end else begin
            cause_r <= cause_r;
            id_r    <= id_r;
        end
    end

    // Next-state and Moore strobes.
    always_comb begin
        state_nxt_s = state_r;
        ir_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        reg_we_s    = 1'b0;
        cp0_we_s    = 1'b0;
        exl_set_s   = 1'b0;
        exl_clr_s   = 1'b0;
        cause_nxt_s = EXC_INT;
        id_nxt_s    = 3'd0;
        case (state_r)
            ST_FETCH: begin
                if (rdy_s) begin
                    ir_we_s     = 1'b1;
                    pc_we_s     = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_EXC;
                    cause_nxt_s = EXC_IBE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (cls_s)
                    CLS_ILLEGAL: begin
                        state_nxt_s = ST_EXC;
                        cause_nxt_s = EXC_RI;
                    end
                    CLS_LOAD, CLS_STORE: state_nxt_s = ST_MEM;
                    CLS_BR:              state_nxt_s = ST_BRANCH;
                    CLS_JMP:             state_nxt_s = ST_JUMP;
                    CLS_ERET:            state_nxt_s = ST_ERET;
                    default:             state_nxt_s = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (is_md) begin
                    state_nxt_s = ST_MDWAIT;
                end else if (cls_s == CLS_MTC0) begin
                    cp0_we_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    reg_we_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            ST_MDWAIT: begin
                if (md_busy) begin
                    state_nxt_s = ST_MDWAIT;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_MEM: begin
                if (rdy_s) begin
                    state_nxt_s = (cls_s == CLS_LOAD) ? ST_WB : ST_DONE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_EXC;
                    cause_nxt_s = EXC_DBE;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_we_s    = 1'b1;
                state_nxt_s = ST_DONE;
            end
            ST_BRANCH: begin
                pc_we_s     = br_taken;
                state_nxt_s = ST_DONE;
            end
            ST_JUMP: begin
                pc_we_s     = 1'b1;
                reg_we_s    = link;
                state_nxt_s = ST_DONE;
            end
            ST_ERET: begin
                exl_clr_s   = 1'b1;
                pc_we_s     = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            ST_DONE: begin
                if (pend_s) begin
                    state_nxt_s = ST_EXC;
                    cause_nxt_s = EXC_INT;
                    id_nxt_s    = pend_id_s;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXC: begin
                exl_set_s   = 1'b1;
                pc_we_s     = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // Reset gates the request combinationally so an in-flight beat is abandoned at once.
    assign bus.bus_req = is_bus_state(state_r) & ~rst;
    assign bus.bus_we  = (state_r == ST_MEM) & (cls_s == CLS_STORE) & ~rst;

    assign ir_we    = ir_we_s;
    assign pc_we    = pc_we_s;
    assign reg_we   = reg_we_s;
    assign cp0_we   = cp0_we_s;
    assign exl_set  = exl_set_s;
    assign exl_clr  = exl_clr_s;
    assign exc_code = (state_r == ST_EXC) ? cause_r : 5'd0;
    assign irq_id   = ((state_r == ST_EXC) && (cause_r == EXC_INT)) ? id_r : 3'd0;
    assign fetch    = (state_r == ST_FETCH);

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: each instruction is expanded into its expected per-cycle phase list
// and compared cycle by cycle; directed cases first, then randomized instruction streams.
module tb_mc_seq_ctrl;
    import mc_pkg::*;

    localparam int IRQ_N = 6;

    // Output vector layout: {req, we, ir_we, pc_we, reg_we, cp0_we, exl_set, exl_clr, code[5], id[3], fetch}
    localparam logic [16:0] REQ = 17'h10000;
    localparam logic [16:0] WE  = 17'h08000;
    localparam logic [16:0] IRW = 17'h04000;
    localparam logic [16:0] PCW = 17'h02000;
    localparam logic [16:0] RGW = 17'h01000;
    localparam logic [16:0] C0W = 17'h00800;
    localparam logic [16:0] XS  = 17'h00400;
    localparam logic [16:0] XC  = 17'h00200;
    localparam logic [16:0] F   = 17'h00001;
    localparam logic [16:0] Z   = 17'h00000;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] cls;
    logic is_md, link, br_taken, md_busy, ie, exl;
    logic [IRQ_N-1:0] irq, irq_mask;
    logic ir_we, pc_we, reg_we, cp0_we, exl_set, exl_clr, fetch;
    logic [4:0] exc_code;
    logic [2:0] irq_id;

    mc_seq_ctrl_if bif();

    always #5 clk = ~clk;

    mc_seq_ctrl #(
        .IRQ_N(IRQ_N)
`ifdef MC_BUS_TIMEOUT_EN
        , .TIMEOUT_W(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .cls(cls), .is_md(is_md), .link(link), .br_taken(br_taken),
        .md_busy(md_busy), .irq(irq), .irq_mask(irq_mask), .ie(ie), .exl(exl), .bus(bif),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .cp0_we(cp0_we), .exl_set(exl_set),
        .exl_clr(exl_clr), .exc_code(exc_code), .irq_id(irq_id), .fetch(fetch)
    );

    typedef struct packed {
        logic        rdy;
        logic        mdb;
        logic [16:0] o;
    } cyc_t;

    cyc_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    tmo_lim  = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [16:0] exc_v(input logic [4:0] code, input logic [2:0] id);
        return XS | PCW | {8'd0, code, id, 1'b0};
    endfunction

    function automatic int low_irq(input logic [IRQ_N-1:0] p);
        for (int i = 0; i < IRQ_N; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    task automatic push(input logic r, input logic m, input logic [16:0] o, input string t);
        cyc_t c;
        c.rdy = r; c.mdb = m; c.o = o;
        exp_q.push_back(c);
        tag_q.push_back(t);
    endtask

    task automatic check(input string tag, input logic [16:0] o_exp);
        logic [16:0] o_obs;
        o_obs = {bif.bus_req, bif.bus_we, ir_we, pc_we, reg_we, cp0_we, exl_set, exl_clr,
                 exc_code, irq_id, fetch};
        n_checks++;
        assert (o_obs === o_exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o_obs, o_exp);
        end
    endtask

    // Expected phase list for one instruction: fw/mw bus wait cycles, mdn busy cycles in MDWAIT.
    task automatic build(input logic [2:0] c, input logic md, input logic lk, input logic bt,
                         input int fw, input int mw, input int mdn);
        logic [IRQ_N-1:0] p;
        logic [16:0]      mwe;
        for (int k = 0; k < fw && !(tmo_lim > 0 && k >= tmo_lim); k++)
            push(1'b0, rb(), REQ | F, "fetch_wait");
        if (tmo_lim > 0 && fw >= tmo_lim) begin
            push(rb(), rb(), exc_v(5'd6, 3'd0), "exc_ibe");
            return;
        end
        push(1'b1, rb(), REQ | IRW | PCW | F, "fetch_rdy");
        push(rb(), rb(), Z, "decode");
        case (c)
            3'd7: begin
                push(rb(), rb(), exc_v(5'd10, 3'd0), "exc_ri");
                return;
            end
            3'd1, 3'd2: begin
                mwe = (c == 3'd2) ? WE : Z;
                for (int k = 0; k < mw && !(tmo_lim > 0 && k >= tmo_lim); k++)
                    push(1'b0, rb(), REQ | mwe, "mem_wait");
                if (tmo_lim > 0 && mw >= tmo_lim) begin
                    push(rb(), rb(), exc_v(5'd7, 3'd0), "exc_dbe");
                    return;
                end
                push(1'b1, rb(), REQ | mwe, "mem_rdy");
                if (c == 3'd1) push(rb(), rb(), RGW, "wb");
            end
            3'd3: push(rb(), rb(), bt ? PCW : Z, "branch");
            3'd4: push(rb(), rb(), PCW | (lk ? RGW : Z), "jump");
            3'd5: begin
                push(rb(), rb(), XC | PCW, "eret");
                return;
            end
            default: begin
                if (md) begin
                    push(rb(), rb(), Z, "exec_md");
                    for (int k = 0; k < mdn; k++) push(rb(), 1'b1, Z, "mdwait_busy");
                    push(rb(), 1'b0, Z, "mdwait_end");
                end else begin
                    push(rb(), rb(), (c == 3'd6) ? C0W : RGW, "exec");
                end
            end
        endcase
        push(rb(), rb(), Z, "done");
        p = irq & irq_mask & {IRQ_N{ie & ~exl}};
        if (p != '0) push(rb(), rb(), exc_v(5'd0, 3'(low_irq(p))), "exc_int");
    endtask

    task automatic run_n(input int n);
        cyc_t  c;
        string t;
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            c = exp_q.pop_front();
            t = tag_q.pop_front();
            bif.bus_rdy = c.rdy;
            md_busy     = c.mdb;
            @(negedge clk);
            check(t, c.o);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ctl(input logic [IRQ_N-1:0] i, input logic [IRQ_N-1:0] m, input logic e, input logic x);
        irq = i; irq_mask = m; ie = e; exl = x;
    endtask

    task automatic instr(input logic [2:0] c, input logic md, input logic lk, input logic bt,
                         input int fw, input int mw, input int mdn);
        cls = c; is_md = md; link = lk; br_taken = bt;
        build(c, md, lk, bt, fw, mw, mdn);
        run_n(exp_q.size());
    endtask

    initial begin
`ifdef MC_BUS_TIMEOUT_EN
        tmo_lim = 15;
`endif
        rst = 1'b1; cls = 3'd0; is_md = 1'b0; link = 1'b0; br_taken = 1'b0; md_busy = 1'b0;
        bif.bus_rdy = 1'b1;
        ctl('1, '1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", F);
        @(posedge clk);
        #1;
        rst = 1'b0;

        ctl('0, '0, 1'b0, 1'b0);
        instr(CLS_ALU, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        instr(CLS_LOAD, 1'b0, 1'b0, 1'b0, 0, 3, 0);
        ctl(6'b001100, 6'b111000, 1'b1, 1'b0);
        instr(CLS_ALU, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        ctl(6'b001100, 6'b111000, 1'b1, 1'b1);
        instr(CLS_ILLEGAL, 1'b0, 1'b0, 1'b0, 1, 0, 0);
        instr(CLS_ALU, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        ctl('0, '0, 1'b0, 1'b0);
        instr(CLS_ALU, 1'b1, 1'b0, 1'b0, 0, 0, 9);
        instr(CLS_STORE, 1'b0, 1'b0, 1'b0, 2, 0, 0);
        instr(CLS_BR, 1'b0, 1'b0, 1'b1, 1, 0, 0);
        instr(CLS_BR, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        instr(CLS_JMP, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        instr(CLS_JMP, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        instr(CLS_MTC0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        instr(CLS_ERET, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        ctl(6'b100000, 6'b100000, 1'b1, 1'b0);
        instr(CLS_JMP, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        ctl('0, '0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a data transfer.
        cls = CLS_LOAD; is_md = 1'b0; link = 1'b0; br_taken = 1'b0;
        build(CLS_LOAD, 1'b0, 1'b0, 1'b0, 0, 6, 0);
        run_n(3);
        bif.bus_rdy = 1'b0;
        #1;
        check("mem_before_rst", REQ);
        rst = 1'b1;
        #1;
        check("rst_mid_mem", F);
        exp_q.delete();
        tag_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr(CLS_LOAD, 1'b0, 1'b0, 1'b0, 1, 1, 0);

        for (int n = 0; n < 200; n++) begin
            logic [2:0] rc;
            logic       rmd;
            rc  = 3'($urandom_range(0, 7));
            rmd = (rc == 3'd0) ? rb() : 1'b0;
            ctl(IRQ_N'($urandom), IRQ_N'($urandom), rb(), 1'($urandom_range(0, 3) == 0));
            instr(rc, rmd, rb(), rb(), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 5));
        end

`ifdef MC_BUS_TIMEOUT_EN
        ctl('0, '0, 1'b0, 1'b0);
        instr(CLS_ALU, 1'b0, 1'b0, 1'b0, 14, 0, 0);
        instr(CLS_ALU, 1'b0, 1'b0, 1'b0, 20, 0, 0);
        instr(CLS_STORE, 1'b0, 1'b0, 1'b0, 0, 20, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
